swd_uart_tx: RTL and testbench

//  Downstream stage of the SWD capture block. Consumes captured bytes (dt + 1-cycle
//  rdy_swd strobe), buffers them in a small synchronous FIFO, and serialises them
//  out as 8N1 UART (LSB first) to the host.

---
 rtl/swd_uart_tx.sv | 167 ++++++++++++++++
 tb/tb_swd_uart_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/swd_uart_tx.sv
// SWD capture to host UART bridge: small FIFO absorbs capture bursts, 8N1 serialiser drains it LSB first.
// state | meaning: IDLE idle high, pops when FIFO non-empty | START start bit | DATA 8 data bits | STOP stop bit
module swd_uart_tx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_AW      = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         dt,
   input  logic               rdy_swd,
   output logic               tx,
   output logic               busy,
   output logic               overflow,
   output logic [FIFO_AW:0]   fifo_level
);

   localparam int                  DEPTH      = 1 << FIFO_AW;
   localparam int                  CW         = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]       BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]       BAUD_ONE   = CW'(1);
   localparam logic [FIFO_AW:0]    LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0]    LEVEL_ONE  = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW-1:0]  PTR_ONE    = FIFO_AW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [7:0]           mem [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr;
   logic [FIFO_AW-1:0]   rd_ptr;
   logic [FIFO_AW:0]     level;
   logic [CW-1:0]        baud_cnt;
   logic [CW-1:0]        baud_cnt_nxt;
   logic [2:0]           bit_idx;
   logic [2:0]           bit_idx_nxt;
   logic [7:0]           shift;
   logic [7:0]           shift_nxt;
   logic                 tx_q;
   logic                 tx_nxt;
   logic                 full;
   logic                 pop;
   logic                 push;
   logic                 baud_done;

   assign full      = (level == LEVEL_FULL);
   assign pop       = (state == S_IDLE) && (level != '0);
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign push      = rdy_swd && (!full || pop);
   assign baud_done = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= dt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   level <= level + LEVEL_ONE;
            2'b01:   level <= level - LEVEL_ONE;
            default: level <= level;
         endcase
         if (rdy_swd && !push) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx_q     <= 1'b1;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         shift    <= shift_nxt;
         tx_q     <= tx_nxt;
      end
   end

   // tx_nxt is the line level for the next cycle, so tx leaves a flop with no decode glitches.
   always_comb begin
      state_nxt    = state;
      baud_cnt_nxt = baud_cnt;
      bit_idx_nxt  = bit_idx;
      shift_nxt    = shift;
      tx_nxt       = tx_q;
      unique case (state)
         S_IDLE: begin
            tx_nxt = 1'b1;
            if (pop) begin
               shift_nxt    = mem[rd_ptr];
               baud_cnt_nxt = '0;
               bit_idx_nxt  = '0;
               tx_nxt       = 1'b0;
               state_nxt    = S_START;
            end
         end
         S_START: begin
            tx_nxt = 1'b0;
            if (baud_done) begin
               baud_cnt_nxt = '0;
               bit_idx_nxt  = '0;
               tx_nxt       = shift[0];
               state_nxt    = S_DATA;
            end else begin
               baud_cnt_nxt = baud_cnt + BAUD_ONE;
            end
         end
         S_DATA: begin
            tx_nxt = shift[0];
            if (baud_done) begin
               baud_cnt_nxt = '0;
               if (bit_idx == 3'd7) begin
                  tx_nxt    = 1'b1;
                  state_nxt = S_STOP;
               end else begin
                  shift_nxt   = {1'b0, shift[7:1]};
                  bit_idx_nxt = bit_idx + 3'd1;
                  tx_nxt      = shift[1];
               end
            end else begin
               baud_cnt_nxt = baud_cnt + BAUD_ONE;
            end
         end
         S_STOP: begin
            tx_nxt = 1'b1;
            if (baud_done) begin
               baud_cnt_nxt = '0;
               state_nxt    = S_IDLE;
            end else begin
               baud_cnt_nxt = baud_cnt + BAUD_ONE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign tx         = tx_q;
   assign busy       = (state != S_IDLE) || (level != '0);
   assign fifo_level = level;

endmodule

// File: tb/tb_swd_uart_tx.sv
// Bench for swd_uart_tx: fast-baud instance for exact waveform/corner cases, 104-clk instance for random traffic.
`timescale 1ns/1ps
module tb_swd_uart_tx;

   localparam int CPB_A = 4;
   localparam int CPB_B = 104;
   localparam int AW    = 2;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    dt_a, dt_b;
   logic          rdy_a, rdy_b;
   logic          tx_a, busy_a, ovf_a;
   logic          tx_b, busy_b, ovf_b;
   logic [AW:0]   lvl_a, lvl_b;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   logic          mon_en = 1'b1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   swd_uart_tx #(.CLKS_PER_BIT(CPB_A), .FIFO_AW(AW)) dut_a (
      .clk(clk), .reset(rst), .dt(dt_a), .rdy_swd(rdy_a),
      .tx(tx_a), .busy(busy_a), .overflow(ovf_a), .fifo_level(lvl_a)
   );

   swd_uart_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_AW(AW)) dut_b (
      .clk(clk), .reset(rst), .dt(dt_b), .rdy_swd(rdy_b),
      .tx(tx_b), .busy(busy_b), .overflow(ovf_b), .fifo_level(lvl_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: FIFO occupancy, frame timer and accepted-byte scoreboard per instance.
   int          m_lvl [2];
   int          m_cnt [2];
   logic        m_ovf [2];
   logic        m_rdy [2];
   logic        m_pop [2];
   logic        m_acc [2];
   logic [7:0]  exp_q0 [$];
   logic [7:0]  exp_q1 [$];

   always_comb begin
      m_rdy[0] = rdy_a;
      m_rdy[1] = rdy_b;
      for (int i = 0; i < 2; i++) begin
         m_pop[i] = (m_cnt[i] == 0) && (m_lvl[i] != 0);
         m_acc[i] = m_rdy[i] && ((m_lvl[i] < DEPTH) || m_pop[i]);
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_lvl[i] <= 0;
            m_cnt[i] <= 0;
            m_ovf[i] <= 1'b0;
         end
         exp_q0.delete();
         exp_q1.delete();
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_rdy[i] && !m_acc[i]) m_ovf[i] <= 1'b1;
            m_lvl[i] <= m_lvl[i] + (m_acc[i] ? 1 : 0) - (m_pop[i] ? 1 : 0);
            if (m_pop[i]) m_cnt[i] <= 10 * ((i == 1) ? CPB_B : CPB_A);
            else if (m_cnt[i] != 0) m_cnt[i] <= m_cnt[i] - 1;
         end
         if (m_acc[0]) exp_q0.push_back(dt_a);
         if (m_acc[1]) exp_q1.push_back(dt_b);
      end
   end

   always @(negedge clk) begin
      check("level_a", lvl_a, m_lvl[0]);
      check("overflow_a", ovf_a, m_ovf[0]);
      check("busy_a", busy_a, (m_cnt[0] != 0) || (m_lvl[0] != 0));
      check("level_b", lvl_b, m_lvl[1]);
      check("overflow_b", ovf_b, m_ovf[1]);
      check("busy_b", busy_b, (m_cnt[1] != 0) || (m_lvl[1] != 0));
   end

   // UART decoder: entered on the first low sample of a start bit, samples each bit mid-cell.
   task automatic decode(input int sel, output logic [7:0] d, output logic stop_bit);
      int cpb;
      cpb = (sel == 1) ? CPB_B : CPB_A;
      repeat (cpb + cpb / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         d[i] = (sel == 1) ? tx_b : tx_a;
         repeat (cpb) @(negedge clk);
      end
      stop_bit = (sel == 1) ? tx_b : tx_a;
   endtask

   logic [7:0] mon_d_a, mon_d_b;
   logic       mon_sb_a, mon_sb_b;
   int         mon_t0_a;
   int         starts_a [$];

   always begin
      @(negedge clk);
      if (!rst && tx_a === 1'b0) begin
         mon_t0_a = cyc;
         decode(0, mon_d_a, mon_sb_a);
         if (mon_en) begin
            starts_a.push_back(mon_t0_a);
            check("stop_bit_a", mon_sb_a, 1'b1);
            check("byte_expected_a", exp_q0.size() != 0, 1'b1);
            if (exp_q0.size() != 0) check("byte_a", mon_d_a, exp_q0.pop_front());
         end
      end
   end

   always begin
      @(negedge clk);
      if (!rst && tx_b === 1'b0) begin
         decode(1, mon_d_b, mon_sb_b);
         check("stop_bit_b", mon_sb_b, 1'b1);
         check("byte_expected_b", exp_q1.size() != 0, 1'b1);
         if (exp_q1.size() != 0) check("byte_b", mon_d_b, exp_q1.pop_front());
      end
   end

   task automatic strobe(input int sel, input logic [7:0] d);
      if (sel == 1) begin
         dt_b  = d;
         rdy_b = 1'b1;
      end else begin
         dt_a  = d;
         rdy_a = 1'b1;
      end
      @(negedge clk);
      rdy_a = 1'b0;
      rdy_b = 1'b0;
   endtask

   task automatic drain(input int sel, input int max_cyc);
      int n;
      n = 0;
      while ((((sel == 1) ? busy_b : busy_a) ||
              (((sel == 1) ? exp_q1.size() : exp_q0.size()) != 0)) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check("drain_in_time", n < max_cyc, 1'b1);
      repeat (4) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] d;
      logic [9:0] frame;
   } vec_t;

   vec_t        vec [5];
   logic [9:0]  fr;
   int          burst;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // frame bits, bit 0 first on the line: start, d[0]..d[7], stop
      vec[0] = '{d: 8'hA5, frame: 10'h34A};
      vec[1] = '{d: 8'h00, frame: 10'h200};
      vec[2] = '{d: 8'hFF, frame: 10'h3FE};
      vec[3] = '{d: 8'h3C, frame: 10'h278};
      vec[4] = '{d: 8'h81, frame: 10'h302};

      rst = 1'b1;
      rdy_a = 1'b0;  rdy_b = 1'b0;
      dt_a = 8'h00;  dt_b = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_tx_a", tx_a, 1'b1);
      check("reset_busy_a", busy_a, 1'b0);
      check("reset_level_a", lvl_a, 0);
      check("reset_tx_b", tx_b, 1'b1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single frames, checked cycle by cycle
      for (int v = 0; v < 5; v++) begin
         fr = vec[v].frame;
         strobe(0, vec[v].d);
         check("tx_before_pop", tx_a, 1'b1);
         for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB_A; c++) begin
               @(negedge clk);
               check("frame_tx", tx_a, fr[b]);
            end
         end
         check("busy_in_stop", busy_a, 1'b1);
         @(negedge clk);
         check("busy_after_stop", busy_a, 1'b0);
         check("tx_idle", tx_a, 1'b1);
         repeat (3) @(negedge clk);
      end

      // Burst of three: in-order output, one idle cycle between frames
      starts_a.delete();
      strobe(0, 8'h01);
      strobe(0, 8'h02);
      strobe(0, 8'h03);
      check("burst_level", lvl_a, 2);
      drain(0, 400);
      check("burst_frames", starts_a.size(), 3);
      if (starts_a.size() == 3) begin
         check("burst_spacing_1", starts_a[1] - starts_a[0], 10 * CPB_A + 1);
         check("burst_spacing_2", starts_a[2] - starts_a[1], 10 * CPB_A + 1);
      end

      // Fill past capacity: sixth byte dropped, overflow sticky
      for (int k = 0; k < 6; k++) strobe(0, 8'h10 + 8'(k));
      check("fill_level", lvl_a, 4);
      check("fill_overflow", ovf_a, 1'b1);
      repeat (100) @(negedge clk);
      check("overflow_sticky", ovf_a, 1'b1);

      // Reset in the middle of a frame with bytes still queued
      check("busy_before_reset", busy_a, 1'b1);
      mon_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midreset_tx", tx_a, 1'b1);
      check("midreset_busy", busy_a, 1'b0);
      check("midreset_level", lvl_a, 0);
      check("midreset_overflow", ovf_a, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      mon_en = 1'b1;

      // Full FIFO + pop + push in the same cycle
      for (int k = 0; k < 5; k++) strobe(0, 8'h20 + 8'(k));
      repeat (10 * CPB_A - 3) @(negedge clk);
      check("full_before_pop", lvl_a, 4);
      strobe(0, 8'h25);
      check("full_pop_push_level", lvl_a, 4);
      check("full_pop_push_no_ovf", ovf_a, 1'b0);
      drain(0, 400);
      check("full_pop_push_ovf_end", ovf_a, 1'b0);

      // Random bursts against the 104-clk instance
      burst = 0;
      for (int c = 0; c < 15000; c++) begin
         if (burst == 0 && $urandom_range(0, 1199) == 0) burst = $urandom_range(1, 7);
         if (burst > 0) begin
            dt_b  = 8'($urandom);
            rdy_b = 1'b1;
            burst--;
         end else begin
            rdy_b = 1'b0;
         end
         @(negedge clk);
      end
      rdy_b = 1'b0;
      drain(1, 8000);
      check("random_overflow", ovf_b, m_ovf[1]);

      check("queue_a_empty", exp_q0.size(), 0);
      check("queue_b_empty", exp_q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
